// File: rtl/note_screen_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// note_screen_scheduler_pkg
// Shared playfield geometry, colour encodings, FSM state and mode encodings for
// the note-window redraw scheduler. No ports; imported by the scheduler top and
// its pixel counter.
// -----------------------------------------------------------------------------
package note_screen_scheduler_pkg;

  // Playfield geometry defaults.
  localparam int             DEF_LANES    = 4;
  localparam int             DEF_ROWS     = 8;
  localparam int             DEF_BLOCK_W  = 8;
  localparam int             DEF_BLOCK_H  = 4;
  localparam logic [7:0]     DEF_X_ORIGIN = 8'd16;
  localparam logic [6:0]     DEF_Y_ORIGIN = 7'd8;

  // Colour encodings: lane l uses bits [3l+2:3l].
  localparam logic [11:0]    DEF_LANE_COLOURS  = 12'b110_100_010_001;
  localparam logic [2:0]     DEF_STRIKE_COLOUR = 3'b111;
  localparam logic [2:0]     COLOUR_BLANK      = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLOT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_DRAW  = 1'b0,
    MODE_CLEAR = 1'b1
  } mode_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/note_screen_scheduler_block_pixel_counter.sv
// -----------------------------------------------------------------------------
// block_pixel_counter
// Nested pixel walker: px (inner) -> py -> lane -> row (outer). Each level wraps
// at its limit and carries into the next outer level. Advances only while en_i.
//   clock, reset : clock and synchronous active-high reset
//   en_i         : advance one pixel this cycle
//   px_o, py_o   : pixel offset inside the current block
//   lane_o, row_o: current block column and row
//   last_o       : counters currently point at the final pixel of the frame
// -----------------------------------------------------------------------------
module block_pixel_counter
  import note_screen_scheduler_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int ROWS    = DEF_ROWS,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int BLOCK_H = DEF_BLOCK_H,
  parameter int PX_W    = cnt_w(BLOCK_W),
  parameter int PY_W    = cnt_w(BLOCK_H),
  parameter int LANE_W  = cnt_w(LANES),
  parameter int ROW_W   = cnt_w(ROWS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_i,
  output logic [PX_W-1:0]   px_o,
  output logic [PY_W-1:0]   py_o,
  output logic [LANE_W-1:0] lane_o,
  output logic [ROW_W-1:0]  row_o,
  output logic              last_o
);

  logic [PX_W-1:0]   px_q;
  logic [PY_W-1:0]   py_q;
  logic [LANE_W-1:0] lane_q;
  logic [ROW_W-1:0]  row_q;

  logic px_wrap, py_wrap, lane_wrap, row_wrap;

  assign px_wrap   = (px_q   == PX_W'(BLOCK_W - 1));
  assign py_wrap   = (py_q   == PY_W'(BLOCK_H - 1));
  assign lane_wrap = (lane_q == LANE_W'(LANES - 1));
  assign row_wrap  = (row_q  == ROW_W'(ROWS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      px_q   <= '0;
      py_q   <= '0;
      lane_q <= '0;
      row_q  <= '0;
    end else if (en_i) begin
      px_q <= px_wrap ? '0 : px_q + 1'b1;
      if (px_wrap) begin
        py_q <= py_wrap ? '0 : py_q + 1'b1;
        if (py_wrap) begin
          lane_q <= lane_wrap ? '0 : lane_q + 1'b1;
          if (lane_wrap) begin
            row_q <= row_wrap ? '0 : row_q + 1'b1;
          end
        end
      end
    end
  end

  assign px_o   = px_q;
  assign py_o   = py_q;
  assign lane_o = lane_q;
  assign row_o  = row_q;
  assign last_o = px_wrap & py_wrap & lane_wrap & row_wrap;

endmodule

// File: rtl/note_screen_scheduler.sv
// -----------------------------------------------------------------------------
// note_screen_scheduler
// Redraws the scrolling note window one pixel per cycle after each beat, or
// blanks the playfield on request, then pulses screen_ready for one cycle.
//   clock, reset  : clock and synchronous active-high reset
//   start_draw    : redraw request (song FSM beat pulse); wins over start_clear
//   start_clear   : blank-playfield request
//   note_window   : bit r*LANES+l = note in row r, lane l; sampled at start only
//   x, y, colour  : registered pixel coordinate and colour to the VGA adapter
//   plot          : pixel write enable
//   busy          : a draw or clear is in progress
//   screen_ready  : one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module note_screen_scheduler
  import note_screen_scheduler_pkg::*;
#(
  parameter int               LANES         = DEF_LANES,
  parameter int               ROWS          = DEF_ROWS,
  parameter int               BLOCK_W       = DEF_BLOCK_W,
  parameter int               BLOCK_H       = DEF_BLOCK_H,
  parameter logic [7:0]       X_ORIGIN      = DEF_X_ORIGIN,
  parameter logic [6:0]       Y_ORIGIN      = DEF_Y_ORIGIN,
  parameter logic [3*LANES-1:0] LANE_COLOURS = DEF_LANE_COLOURS,
  parameter logic [2:0]       STRIKE_COLOUR = DEF_STRIKE_COLOUR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_draw,
  input  logic                   start_clear,
  input  logic [LANES*ROWS-1:0]  note_window,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   screen_ready
);

  localparam int PX_W   = cnt_w(BLOCK_W);
  localparam int PY_W   = cnt_w(BLOCK_H);
  localparam int LANE_W = cnt_w(LANES);
  localparam int ROW_W  = cnt_w(ROWS);

  state_e                state_q;
  mode_e                 mode_q;
  logic [LANES*ROWS-1:0] window_q;
  logic                  last_q;    // pixel currently on the outputs is the final one
  logic [7:0]            x_q;
  logic [6:0]            y_q;
  logic [2:0]            colour_q;
  logic                  plot_q, busy_q, ready_q;

  logic [PX_W-1:0]   px;
  logic [PY_W-1:0]   py;
  logic [LANE_W-1:0] lane;
  logic [ROW_W-1:0]  row;
  logic              cnt_last, cnt_en, start_any;

  mode_e                 sel_mode;
  logic [LANES*ROWS-1:0] sel_window;
  logic [7:0]            pix_x;
  logic [6:0]            pix_y;
  logic [2:0]            pix_colour;
  logic                  note_bit;

  assign start_any = start_draw | start_clear;

  // The counter always rests at pixel 0 while idle, so pixel 0 is emitted on the
  // start edge and the counter steps in the same cycle it is consumed.
  assign cnt_en = ((state_q == ST_IDLE) && start_any) ||
                  ((state_q == ST_PLOT) && !last_q);

  block_pixel_counter #(
    .LANES  (LANES),
    .ROWS   (ROWS),
    .BLOCK_W(BLOCK_W),
    .BLOCK_H(BLOCK_H)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .en_i  (cnt_en),
    .px_o  (px),
    .py_o  (py),
    .lane_o(lane),
    .row_o (row),
    .last_o(cnt_last)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    sel_mode   = mode_q;
    sel_window = window_q;
    // On the start edge the latches are not loaded yet; use the live inputs.
    if (state_q == ST_IDLE) begin
      sel_mode   = start_draw ? MODE_DRAW : MODE_CLEAR;
      sel_window = note_window;
    end

    // Coordinates wrap modulo the port width.
    pix_x = X_ORIGIN + 8'(int'(lane) * BLOCK_W) + 8'(px);
    pix_y = Y_ORIGIN + 7'(int'(row) * BLOCK_H) + 7'(py);

    note_bit   = sel_window[int'(row) * LANES + int'(lane)];
    pix_colour = COLOUR_BLANK;
    if (sel_mode == MODE_DRAW) begin
      if (note_bit) begin
        pix_colour = LANE_COLOURS[3 * int'(lane) +: 3];
      end else if (int'(row) == ROWS - 1) begin
        pix_colour = STRIKE_COLOUR;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_DRAW;
      window_q <= '0;
      last_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (start_any) begin
            state_q  <= ST_PLOT;
            mode_q   <= sel_mode;
            if (start_draw) window_q <= note_window;
            x_q      <= pix_x;
            y_q      <= pix_y;
            colour_q <= pix_colour;
            plot_q   <= 1'b1;
            busy_q   <= 1'b1;
            last_q   <= cnt_last;
          end
        end
        ST_PLOT: begin
          if (last_q) begin
            state_q <= ST_DONE;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            last_q  <= 1'b0;
          end else begin
            x_q      <= pix_x;
            y_q      <= pix_y;
            colour_q <= pix_colour;
            last_q   <= cnt_last;
          end
        end
        ST_DONE: begin
          // Requests arriving here are dropped, not queued.
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign busy         = busy_q;
  assign screen_ready = ready_q;

endmodule

// File: tb/tb_note_screen_scheduler.sv
// -----------------------------------------------------------------------------
// tb_note_screen_scheduler
// Self-checking bench: expected pixels are pushed to a scoreboard queue when a
// request is driven and popped as the DUT plots. A second instance with
// X_ORIGIN=240 shares the stimulus and is checked only in the wrap test.
// -----------------------------------------------------------------------------
module tb_note_screen_scheduler;

  localparam int N = 1024;

  logic        clock = 1'b0;
  logic        reset, start_draw, start_clear;
  logic [31:0] note_window;

  logic [7:0] x1, x2;
  logic [6:0] y1, y2;
  logic [2:0] c1, c2;
  logic       plot1, plot2, busy1, busy2, rdy1, rdy2;

  note_screen_scheduler dut (
    .clock(clock), .reset(reset), .start_draw(start_draw), .start_clear(start_clear),
    .note_window(note_window), .x(x1), .y(y1), .colour(c1), .plot(plot1),
    .busy(busy1), .screen_ready(rdy1)
  );

  note_screen_scheduler #(.X_ORIGIN(8'd240)) dut_wrap (
    .clock(clock), .reset(reset), .start_draw(start_draw), .start_clear(start_clear),
    .note_window(note_window), .x(x2), .y(y2), .colour(c2), .plot(plot2),
    .busy(busy2), .screen_ready(rdy2)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs[N];

  int passed = 0;
  int total  = 0;

  // Per-frame observations.
  int   plot_cnt, first_i, ready_cnt, ready_i, pix_bad, busy_bad;
  pix_t bad_got, bad_exp;
  int   bad_idx;
  logic rst_plot, rst_busy;

  // Mid-frame stimulus hooks (cycle index after the start edge, -1 = off).
  int          hook_window_at = -1;
  int          hook_draw_at   = -1;
  int          hook_reset_at  = -1;
  logic [31:0] hook_window    = '0;

  function automatic logic [2:0] model_colour(input bit clr, input logic [31:0] w,
                                              input int r, input int l);
    logic [11:0] lc;
    lc = 12'b110_100_010_001;
    if (clr) return 3'b000;
    if (w[r*4+l]) return lc[l*3 +: 3];
    if (r == 7) return 3'b111;
    return 3'b000;
  endfunction

  task automatic push_frame(input bit clr, input logic [31:0] w, input logic [7:0] xo);
    pix_t p;
    for (int r = 0; r < 8; r++)
      for (int l = 0; l < 4; l++)
        for (int py = 0; py < 4; py++)
          for (int px = 0; px < 8; px++) begin
            p.x = xo + 8'(l*8 + px);
            p.y = 7'd8 + 7'(r*4 + py);
            p.c = model_colour(clr, w, r, l);
            exp_q.push_back(p);
          end
  endtask

  // Drive a request for one edge; returns just after that edge.
  task automatic start_req(input bit d, input bit c, input logic [31:0] w);
    @(negedge clock);
    start_draw  = d;
    start_clear = c;
    note_window = w;
    @(posedge clock);
    #1;
    start_draw  = 1'b0;
    start_clear = 1'b0;
  endtask

  // Sample max_i cycles after the start edge, scoring plotted pixels.
  task automatic observe(input bit use2, input int max_i);
    logic [7:0] ox; logic [6:0] oy; logic [2:0] oc; logic op, ob, orr;
    pix_t p, got;
    plot_cnt = 0; first_i = -1; ready_cnt = 0; ready_i = -1;
    pix_bad = 0; busy_bad = 0; bad_idx = -1;
    for (int i = 1; i <= max_i; i++) begin
      @(negedge clock);
      ox  = use2 ? x2 : x1;     oy = use2 ? y2 : y1;     oc = use2 ? c2 : c1;
      op  = use2 ? plot2 : plot1;
      ob  = use2 ? busy2 : busy1;
      orr = use2 ? rdy2 : rdy1;
      got = {ox, oy, oc};
      if (op === 1'b1) begin
        if (first_i < 0) first_i = i;
        if (plot_cnt < N) obs[plot_cnt] = got;
        if (exp_q.size() == 0) begin
          pix_pad_bad(got, '0, plot_cnt);
        end else begin
          p = exp_q.pop_front();
          if (got !== p) pix_pad_bad(got, p, plot_cnt);
        end
        plot_cnt++;
      end
      if (ob !== op) busy_bad++;
      if (orr === 1'b1) begin
        ready_cnt++;
        if (ready_i < 0) ready_i = i;
      end
      if (i == hook_window_at) note_window = hook_window;
      if (i == hook_draw_at) start_draw = 1'b1;
      if (i == hook_draw_at + 1) start_draw = 1'b0;
      if (i == hook_reset_at) reset = 1'b1;
      if (i == hook_reset_at + 1) begin
        rst_plot = op;
        rst_busy = ob;
        reset    = 1'b0;
      end
    end
  endtask

  task automatic pix_pad_bad(input pix_t got, input pix_t e, input int idx);
    if (pix_bad == 0) begin
      bad_got = got; bad_exp = e; bad_idx = idx;
    end
    pix_bad++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_draw = 1'b0; start_clear = 1'b0; note_window = '0;
    repeat (3) @(negedge clock);
    total++; if (plot1 !== 1'b0) $display("FAIL reset plot: got %b expected 0", plot1); else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy1); else passed++;
    total++; if (rdy1 !== 1'b0) $display("FAIL reset screen_ready: got %b expected 0", rdy1); else passed++;
    total++; if ({x1, y1, c1} !== 18'd0) $display("FAIL reset xyc: got %0d,%0d,%0d expected 0,0,0", x1, y1, c1); else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_draw_empty();
    exp_q.delete();
    push_frame(1'b0, 32'h0, 8'd16);
    start_req(1'b1, 1'b0, 32'h0);
    observe(1'b0, N + 3);
    total++; if (plot_cnt !== N) $display("FAIL draw_empty plot_count: got %0d expected %0d", plot_cnt, N); else passed++;
    total++; if (first_i !== 1) $display("FAIL draw_empty first_plot_cycle: got %0d expected 1", first_i); else passed++;
    total++; if (pix_bad !== 0) $display("FAIL draw_empty pixels: %0d bad, first at %0d got %h expected %h", pix_bad, bad_idx, bad_got, bad_exp); else passed++;
    total++; if (obs[0] !== {8'd16, 7'd8, 3'd0}) $display("FAIL draw_empty first_pixel: got %h expected %h", obs[0], {8'd16, 7'd8, 3'd0}); else passed++;
    total++; if (obs[896] !== {8'd16, 7'd36, 3'd7}) $display("FAIL draw_empty strike_pixel: got %h expected %h", obs[896], {8'd16, 7'd36, 3'd7}); else passed++;
    total++; if (ready_cnt !== 1 || ready_i !== N + 1) $display("FAIL draw_empty screen_ready: got count %0d at %0d expected 1 at %0d", ready_cnt, ready_i, N + 1); else passed++;
    total++; if (busy_bad !== 0) $display("FAIL draw_empty busy_vs_plot: got %0d disagreements expected 0", busy_bad); else passed++;
  endtask

  task automatic test_draw_notes();
    logic [31:0] w;
    w = 32'h8000_0001;
    exp_q.delete();
    push_frame(1'b0, w, 8'd16);
    start_req(1'b1, 1'b0, w);
    observe(1'b0, N + 3);
    total++; if (pix_bad !== 0 || plot_cnt !== N) $display("FAIL draw_notes pixels: %0d bad of %0d, first at %0d got %h expected %h", pix_bad, plot_cnt, bad_idx, bad_got, bad_exp); else passed++;
    total++; if (obs[0].c !== 3'b001) $display("FAIL draw_notes lane0_colour: got %b expected 001", obs[0].c); else passed++;
    total++; if (obs[992] !== {8'd40, 7'd36, 3'b110}) $display("FAIL draw_notes lane3_strike: got %h expected %h", obs[992], {8'd40, 7'd36, 3'b110}); else passed++;
    total++; if (obs[32].c !== 3'b000) $display("FAIL draw_notes empty_block: got %b expected 000", obs[32].c); else passed++;
    total++; if (ready_cnt !== 1) $display("FAIL draw_notes screen_ready: got %0d expected 1", ready_cnt); else passed++;
  endtask

  task automatic test_clear();
    exp_q.delete();
    push_frame(1'b1, 32'hFFFF_FFFF, 8'd16);
    start_req(1'b0, 1'b1, 32'hFFFF_FFFF);
    observe(1'b0, N + 3);
    total++; if (plot_cnt !== N) $display("FAIL clear plot_count: got %0d expected %0d", plot_cnt, N); else passed++;
    total++; if (pix_bad !== 0) $display("FAIL clear pixels: %0d bad, first at %0d got %h expected %h", pix_bad, bad_idx, bad_got, bad_exp); else passed++;
    total++; if (obs[896].c !== 3'b000) $display("FAIL clear strike_colour: got %b expected 000", obs[896].c); else passed++;
    total++; if (ready_cnt !== 1 || ready_i !== N + 1) $display("FAIL clear screen_ready: got count %0d at %0d expected 1 at %0d", ready_cnt, ready_i, N + 1); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    w = 32'h0000_0F0F;
    exp_q.delete();
    push_frame(1'b0, w, 8'd16);
    start_req(1'b1, 1'b1, w);
    observe(1'b0, N + 3);
    total++; if (pix_bad !== 0 || plot_cnt !== N) $display("FAIL both draw_wins: %0d bad of %0d, first at %0d got %h expected %h", pix_bad, plot_cnt, bad_idx, bad_got, bad_exp); else passed++;
    observe(1'b0, 20);
    total++; if (plot_cnt !== 0) $display("FAIL both no_clear_follows: got %0d plots expected 0", plot_cnt); else passed++;
  endtask

  task automatic test_ignore_during_draw();
    logic [31:0] w;
    w = 32'h1234_5678;
    exp_q.delete();
    push_frame(1'b0, w, 8'd16);
    hook_window = ~w; hook_window_at = 10; hook_draw_at = 500;
    start_req(1'b1, 1'b0, w);
    observe(1'b0, N + 3);
    hook_window_at = -1; hook_draw_at = -1;
    total++; if (pix_bad !== 0 || plot_cnt !== N) $display("FAIL ignore pixels: %0d bad of %0d, first at %0d got %h expected %h", pix_bad, plot_cnt, bad_idx, bad_got, bad_exp); else passed++;
    total++; if (ready_cnt !== 1) $display("FAIL ignore screen_ready: got %0d expected 1", ready_cnt); else passed++;
    observe(1'b0, 20);
    total++; if (plot_cnt !== 0 || ready_cnt !== 0) $display("FAIL ignore no_queued_frame: got %0d plots %0d ready expected 0 0", plot_cnt, ready_cnt); else passed++;
  endtask

  task automatic test_reset_mid_draw();
    logic [31:0] w;
    w = 32'hA5A5_5A5A;
    exp_q.delete();
    push_frame(1'b0, w, 8'd16);
    hook_reset_at = 300;
    start_req(1'b1, 1'b0, w);
    observe(1'b0, 340);
    hook_reset_at = -1;
    total++; if (rst_plot !== 1'b0 || rst_busy !== 1'b0) $display("FAIL reset_mid drop: got plot %b busy %b expected 0 0", rst_plot, rst_busy); else passed++;
    total++; if (plot_cnt !== 300 || pix_bad !== 0) $display("FAIL reset_mid partial: got %0d plots %0d bad expected 300 0", plot_cnt, pix_bad); else passed++;
    total++; if (ready_cnt !== 0) $display("FAIL reset_mid screen_ready: got %0d expected 0", ready_cnt); else passed++;
    // A fresh frame after the abort must start from pixel 0.
    w = 32'h0F00_00F0;
    exp_q.delete();
    push_frame(1'b0, w, 8'd16);
    start_req(1'b1, 1'b0, w);
    observe(1'b0, N + 3);
    total++; if (pix_bad !== 0 || plot_cnt !== N) $display("FAIL reset_mid refresh: %0d bad of %0d, first at %0d got %h expected %h", pix_bad, plot_cnt, bad_idx, bad_got, bad_exp); else passed++;
    total++; if (ready_cnt !== 1 || ready_i !== N + 1) $display("FAIL reset_mid refresh_ready: got count %0d at %0d expected 1 at %0d", ready_cnt, ready_i, N + 1); else passed++;
  endtask

  task automatic test_x_wrap();
    exp_q.delete();
    push_frame(1'b0, 32'h0000_0004, 8'd240);
    start_req(1'b1, 1'b0, 32'h0000_0004);
    observe(1'b1, N + 3);
    total++; if (plot_cnt !== N) $display("FAIL wrap plot_count: got %0d expected %0d", plot_cnt, N); else passed++;
    total++; if (pix_bad !== 0) $display("FAIL wrap pixels: %0d bad, first at %0d got %h expected %h", pix_bad, bad_idx, bad_got, bad_exp); else passed++;
    total++; if (obs[64] !== {8'd0, 7'd8, 3'b100}) $display("FAIL wrap lane2_px0: got %h expected %h", obs[64], {8'd0, 7'd8, 3'b100}); else passed++;
    total++; if (ready_cnt !== 1) $display("FAIL wrap screen_ready: got %0d expected 1", ready_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_draw_empty();
    test_draw_notes();
    test_clear();
    test_back_to_back();
    test_ignore_during_draw();
    test_reset_mid_draw();
    test_x_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
